// File: rtl/d5m_axi_lite_cfg_master_if.sv
// ---------------------------------------------------------------------------
// d5m_axi_lite_cfg_master_if
//   AXI4-Lite register bus between the config master and the camera /
//   video-filter config slave.
//   Parameters: ADDR_W (AWADDR/ARADDR width), DATA_W (WDATA/RDATA width;
//   WSTRB is DATA_W/8 bits).
//   Channels: AW (AWADDR, AWPROT, AWVALID, AWREADY)
//             W  (WDATA, WSTRB, WVALID, WREADY)
//             B  (BRESP, BVALID, BREADY)
//             AR (ARADDR, ARPROT, ARVALID, ARREADY)
//             R  (RDATA, RRESP, RVALID, RREADY)
//   Modports: master (initiator view), slave (target view).
// ---------------------------------------------------------------------------
interface d5m_axi_lite_cfg_master_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input  AWREADY,
    output WDATA, WSTRB, WVALID,    input  WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input  ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input  BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input  RREADY
  );
endinterface

// File: rtl/d5m_axi_lite_cfg_master.sv
// ---------------------------------------------------------------------------
// d5m_axi_lite_cfg_master
//   AXI4-Lite initiator for the camera / video-filter register bus. Takes one
//   register command at a time on the cmd port, runs a single-beat write or
//   read, and returns BRESP/RRESP (+ read data) on the rsp port.
//   Ports: ACLK, reset (sync, active-high)
//          cmd_valid/cmd_ready, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb
//          rsp_valid/rsp_ready, rsp_rdata, rsp_resp, rsp_timeout
//          axi : d5m_axi_lite_cfg_master_if.master (AW/W/B/AR/R channels)
//   All outputs come from flops.
//   Optional: define D5M_CFG_MASTER_TIMEOUT_EN to add a watchdog that abandons
//   a transaction after TIMEOUT_CYC busy cycles (rsp_resp=2'b10,
//   rsp_timeout=1). Without it the block waits forever and rsp_timeout is 0.
// ---------------------------------------------------------------------------
module d5m_axi_lite_cfg_master #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                  ACLK,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  d5m_axi_lite_cfg_master_if.master axi
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;
  state_t state, state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q;
  logic aw_valid_d, w_valid_d, ar_valid_d, b_ready_d, r_ready_d;
  logic cmd_ready_d, rsp_valid_d, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic [1:0]        rsp_resp_d;
  logic cmd_hs, done, wd_fire, aw_done, w_done;

  assign cmd_hs  = cmd_valid & cmd_ready;
  // BREADY/RREADY are always high in WR_B/RD_R, so VALID alone completes.
  assign done    = ((state == WR_B) && axi.BVALID) || ((state == RD_R) && axi.RVALID);
  assign aw_done = !aw_valid_q || axi.AWREADY;
  assign w_done  = !w_valid_q  || axi.WREADY;

`ifdef D5M_CFG_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             busy;

  assign busy = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_R);

  // Saturates at the limit so a stage change cannot skip past the compare.
  always_ff @(posedge ACLK) begin
    if (reset || !busy)          wd_cnt <= '0;
    else if (wd_cnt != CNT_LIMIT) wd_cnt <= wd_cnt + CNT_W'(1);
  end

  // A completing handshake in the limit cycle takes priority over the abort.
  assign wd_fire = busy && (wd_cnt == CNT_LIMIT) && !done;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign wd_fire = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge ACLK) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      b_ready_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state       <= state_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_resp    <= rsp_resp_d;
      rsp_timeout <= rsp_timeout_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      ar_valid_q  <= ar_valid_d;
      b_ready_q   <= b_ready_d;
      r_ready_q   <= r_ready_d;
      if (cmd_hs) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
      end
    end
  end

  // Next state
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (cmd_hs) state_d = cmd_wr ? WR : RD_A;
      WR:   if (wd_fire) state_d = RSP; else if (aw_done && w_done) state_d = WR_B;
      WR_B: if (axi.BVALID || wd_fire) state_d = RSP;
      RD_A: if (wd_fire) state_d = RSP; else if (axi.ARREADY) state_d = RD_R;
      RD_R: if (axi.RVALID || wd_fire) state_d = RSP;
      RSP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    aw_valid_d    = (state == IDLE && cmd_hs && cmd_wr)
                 || (state == WR && !wd_fire && aw_valid_q && !axi.AWREADY);
    w_valid_d     = (state == IDLE && cmd_hs && cmd_wr)
                 || (state == WR && !wd_fire && w_valid_q && !axi.WREADY);
    ar_valid_d    = (state == IDLE && cmd_hs && !cmd_wr)
                 || (state == RD_A && !wd_fire && !axi.ARREADY);
    b_ready_d     = (state_d == WR_B);
    r_ready_d     = (state_d == RD_R);
    cmd_ready_d   = (state_d == IDLE);
    rsp_valid_d   = (state_d == RSP);
    rsp_rdata_d   = rsp_rdata;
    rsp_resp_d    = rsp_resp;
    rsp_timeout_d = rsp_timeout;
    if (state == WR_B && axi.BVALID) begin
      rsp_rdata_d   = '0;
      rsp_resp_d    = axi.BRESP;
      rsp_timeout_d = 1'b0;
    end else if (state == RD_R && axi.RVALID) begin
      rsp_rdata_d   = axi.RDATA;
      rsp_resp_d    = axi.RRESP;
      rsp_timeout_d = 1'b0;
    end else if (wd_fire) begin
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
    end
  end

  assign axi.AWADDR  = addr_q;
  assign axi.AWPROT  = '0;
  assign axi.AWVALID = aw_valid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WVALID  = w_valid_q;
  assign axi.BREADY  = b_ready_q;
  assign axi.ARADDR  = addr_q;
  assign axi.ARPROT  = '0;
  assign axi.ARVALID = ar_valid_q;
  assign axi.RREADY  = r_ready_q;

endmodule

// File: tb/tb_d5m_axi_lite_cfg_master.sv
module tb_d5m_axi_lite_cfg_master;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int BOUND = 300;

  logic        ACLK, reset;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  d5m_axi_lite_cfg_master_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  d5m_axi_lite_cfg_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .ACLK(ACLK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .axi(axi)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Slave behaviour knobs (set by the stimulus before each command)
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0] bresp_k = 2'b00, rresp_k = 2'b00;
  bit allow_abort = 0, slave_flush = 0, saw_bvalid = 0;

  // Reference memory (from commands) and slave memory (from observed AXI traffic)
  logic [31:0] model_mem [256];
  logic [31:0] slave_mem [256];

  function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
  endfunction

  // ---------------- AXI-Lite slave with protocol checks ----------------
  logic p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
  logic p_arvalid, p_arready, p_rvalid, p_rready, p_reset;
  logic [7:0]  p_awaddr, p_araddr, s_awaddr, r_addr;
  logic [31:0] p_wdata, s_wdata;
  logic [3:0]  p_wstrb, s_wstrb;
  bit have_aw, have_w, b_pend, r_pend;
  int b_cnt, r_cnt, aw_seen, w_seen, ar_seen;

  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = '0;
      model_mem[i] = '0;
    end
    axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0;
    axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = 0; axi.RRESP = 0;
    {p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready} = '0;
    {p_arvalid, p_arready, p_rvalid, p_rready} = '0;
    p_reset = 1; p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_wstrb = 0;
    have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
    b_cnt = 0; r_cnt = 0; aw_seen = 0; w_seen = 0; ar_seen = 0;
    s_awaddr = 0; s_wdata = 0; s_wstrb = 0; r_addr = 0;
    forever begin
      @(posedge ACLK);
      #2;
      aw_hs = p_awvalid && p_awready;
      w_hs  = p_wvalid && p_wready;
      b_hs  = p_bvalid && p_bready;
      ar_hs = p_arvalid && p_arready;
      r_hs  = p_rvalid && p_rready;
      if (!p_reset) begin
        if (p_awvalid && !aw_hs && !allow_abort)
          check("aw_hold", {axi.AWVALID, axi.AWADDR}, {1'b1, p_awaddr});
        if (p_wvalid && !w_hs && !allow_abort)
          check("w_hold", {axi.WVALID, axi.WDATA, axi.WSTRB}, {1'b1, p_wdata, p_wstrb});
        if (p_arvalid && !ar_hs && !allow_abort)
          check("ar_hold", {axi.ARVALID, axi.ARADDR}, {1'b1, p_araddr});
        if (aw_hs) check("awvalid_drop", axi.AWVALID, 0);
        if (w_hs)  check("wvalid_drop", axi.WVALID, 0);
        if (ar_hs) check("arvalid_drop", axi.ARVALID, 0);
        if (b_hs)  check("bready_drop", axi.BREADY, 0);
        if (r_hs)  check("rready_drop", axi.RREADY, 0);
        if (axi.AWVALID) check("awprot", axi.AWPROT, 0);
        if (axi.ARVALID) check("arprot", axi.ARPROT, 0);
      end
      if (slave_flush) begin
        have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
      end else begin
        if (aw_hs) begin have_aw = 1; s_awaddr = p_awaddr; end
        if (w_hs)  begin have_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; end
        if (b_hs) b_pend = 0;
        if (have_aw && have_w) begin
          for (int i = 0; i < 4; i++)
            if (s_wstrb[i]) slave_mem[s_awaddr][8*i +: 8] = s_wdata[8*i +: 8];
          have_aw = 0; have_w = 0; b_pend = 1; b_cnt = 0;
        end
        if (r_hs) r_pend = 0;
        if (ar_hs) begin r_pend = 1; r_cnt = 0; r_addr = p_araddr; end
      end
      axi.AWREADY = axi.AWVALID && (aw_seen >= aw_lat);
      aw_seen = axi.AWVALID ? aw_seen + 1 : 0;
      axi.WREADY = axi.WVALID && (w_seen >= w_lat);
      w_seen = axi.WVALID ? w_seen + 1 : 0;
      axi.ARREADY = axi.ARVALID && (ar_seen >= ar_lat);
      ar_seen = axi.ARVALID ? ar_seen + 1 : 0;
      axi.BVALID = b_pend && (b_cnt >= b_lat);
      if (b_pend) b_cnt++;
      axi.BRESP = axi.BVALID ? bresp_k : 2'($urandom);
      if (axi.BVALID) saw_bvalid = 1;
      axi.RVALID = r_pend && (r_cnt >= r_lat);
      if (r_pend) r_cnt++;
      axi.RDATA = axi.RVALID ? slave_mem[r_addr] : $urandom;
      axi.RRESP = axi.RVALID ? rresp_k : 2'($urandom);
      p_awvalid = axi.AWVALID; p_awready = axi.AWREADY; p_awaddr = axi.AWADDR;
      p_wvalid = axi.WVALID; p_wready = axi.WREADY; p_wdata = axi.WDATA; p_wstrb = axi.WSTRB;
      p_bvalid = axi.BVALID; p_bready = axi.BREADY;
      p_arvalid = axi.ARVALID; p_arready = axi.ARREADY; p_araddr = axi.ARADDR;
      p_rvalid = axi.RVALID; p_rready = axi.RREADY;
      p_reset = reset;
    end
  end

  // ---------------- command driver / response collector ----------------
  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_l, w_l, b_l, ar_l, r_l;
    logic [1:0]  bresp, rresp;
    int          hold;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    bit          exp_to;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int n, lat;
    logic [31:0] rd;
    logic [1:0]  rs;
    aw_lat = v.aw_l; w_lat = v.w_l; b_lat = v.b_l; ar_lat = v.ar_l; r_lat = v.r_l;
    bresp_k = v.bresp; rresp_k = v.rresp;
    cmd_valid = 1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
    n = 0;
    while (!cmd_ready && n < BOUND) begin tick(); n++; end
    if (!cmd_ready) begin
      check({tag, "_cmd_accept"}, cmd_ready, 1);
      cmd_valid = 0;
      return;
    end
    tick();
    // Fields must have been latched: scramble them right after the handshake.
    cmd_valid = 0; cmd_wr = 1'($urandom); cmd_addr = 8'($urandom);
    cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < BOUND) begin
      check({tag, "_cmd_ready_busy"}, cmd_ready, 0);
      tick(); lat++;
    end
    if (!rsp_valid) begin
      check({tag, "_rsp_timeout_bound"}, rsp_valid, 1);
      return;
    end
    rd = rsp_rdata; rs = rsp_resp;
    check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, "_resp"}, rsp_resp, v.exp_resp);
    check({tag, "_timeout"}, rsp_timeout, v.exp_to);
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_axi_quiet"},
          {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY}, 0);
    for (int i = 0; i < v.hold; i++) begin
      tick();
      check({tag, "_rsp_stable"}, {rsp_valid, cmd_ready, rsp_rdata, rsp_resp},
            {1'b1, 1'b0, rd, rs});
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check({tag, "_idle_after_rsp"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  vec_t vecs [11];

  initial begin
    vec_t v;
    int n;
    reset = 1; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    repeat (3) tick();
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_outputs", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, 0);
    check("reset_axi", {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY}, 0);
    reset = 0;
    tick();

    //        wr addr   wdata          strb  aw w b ar r  bresp  rresp  hold rdata          resp   to lat
    vecs[0]  = '{1, 8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 0, 3};
    vecs[1]  = '{0, 8'h04, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'hDEADBEEF, 2'b00, 0, 3};
    vecs[2]  = '{1, 8'h08, 32'h00001234, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 0, 3};
    vecs[3]  = '{0, 8'h08, 32'h0,        4'h0, 0, 0, 0, 0, 5, 2'b00, 2'b00, 0, 32'h00001234, 2'b00, 0, 8};
    vecs[4]  = '{1, 8'h0C, 32'hCAFEF00D, 4'hF, 3, 0, 0, 0, 0, 2'b10, 2'b00, 0, 32'h0,        2'b10, 0, 6};
    vecs[5]  = '{0, 8'h0C, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 10, 32'hCAFEF00D, 2'b01, 0, 3};
    vecs[6]  = '{1, 8'h04, 32'h00005A00, 4'h2, 1, 2, 1, 0, 0, 2'b01, 2'b00, 0, 32'h0,        2'b01, 0, 6};
    vecs[7]  = '{0, 8'h04, 32'h0,        4'h0, 0, 0, 0, 2, 1, 2'b00, 2'b11, 0, 32'hDEAD5AEF, 2'b11, 0, 6};
    vecs[8]  = '{0, 8'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 0, 3};
    vecs[9]  = '{1, 8'h10, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 0, 3};
    vecs[10] = '{0, 8'h10, 32'h0,        4'h0, 0, 0, 2, 0, 0, 2'b00, 2'b00, 1, 32'h0,        2'b00, 0, 3};

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
    end

    // Reset while waiting for B: everything drops, the late BVALID is ignored.
    aw_lat = 0; w_lat = 0; b_lat = 6; bresp_k = 2'b00;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 8'h14; cmd_wdata = 32'h11223344; cmd_wstrb = 4'hF;
    n = 0;
    while (!cmd_ready && n < BOUND) begin tick(); n++; end
    tick();
    cmd_valid = 0;
    n = 0;
    while (!axi.BREADY && n < BOUND) begin tick(); n++; end
    check("rst_reach_wr_b", axi.BREADY, 1);
    saw_bvalid = 0;
    reset = 1;
    tick();
    reset = 0;
    check("rst_drop", {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY,
                       rsp_valid, cmd_ready}, 7'b0000001);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_late_b_ignored", {axi.BREADY, rsp_valid, cmd_ready}, 3'b001);
    end
    check("rst_late_bvalid_seen", saw_bvalid, 1);
    slave_flush = 1;
    tick();
    slave_flush = 0;
    tick();
    // The slave had already taken both AW and W before the reset.
    model_write(8'h14, 32'h11223344, 4'hF);

`ifdef D5M_CFG_MASTER_TIMEOUT_EN
    // Slave never accepts AR: abort after TO busy cycles.
    allow_abort = 1;
    v = '{0, 8'h04, 32'h0, 4'h0, 0, 0, 0, 1000000, 0, 2'b00, 2'b00, 2,
          32'h0, 2'b10, 1, TO + 1};
    run_vec(v, "timeout");
    tick();
    allow_abort = 0;
`endif

    // Randomized traffic against the reference memory
    for (int i = 0; i < 60; i++) begin
      v.wr    = 1'($urandom);
      v.addr  = {4'h0, 4'($urandom_range(0, 15))} << 2;
      v.wdata = $urandom;
      v.strb  = 4'($urandom);
      v.aw_l  = $urandom_range(0, 3);
      v.w_l   = $urandom_range(0, 3);
      v.b_l   = $urandom_range(0, 3);
      v.ar_l  = $urandom_range(0, 3);
      v.r_l   = $urandom_range(0, 3);
      v.bresp = 2'($urandom);
      v.rresp = 2'($urandom);
      v.hold  = $urandom_range(0, 2);
      v.exp_to = 0;
      if (v.wr) begin
        v.exp_rdata = 0;
        v.exp_resp  = v.bresp;
        v.exp_lat   = 3 + ((v.aw_l > v.w_l) ? v.aw_l : v.w_l) + v.b_l;
      end else begin
        v.exp_rdata = model_mem[v.addr];
        v.exp_resp  = v.rresp;
        v.exp_lat   = 3 + v.ar_l + v.r_l;
      end
      run_vec(v, $sformatf("rnd%0d", i));
      if (v.wr) model_write(v.addr, v.wdata, v.strb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
